// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared widths, arbiter state type and counter sizing helper
//
// Purpose: common definitions for the data-memory arbiter.
//   RISCV_ADDR_WIDTH : byte address width of the data-memory port
//   RISCV_WORD_WIDTH : data word width of the data-memory port
//   arb_state_e      : arbiter FSM states (IDLE, BUSY)
//   arb_cnt_width()  : width of the BUSY-cycle counter for a given timeout

package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Counter must hold 0..TIMEOUT; a disabled timeout still needs one bit.
    function automatic int arb_cnt_width(input int timeout);
        int w;
        if (timeout <= 0) begin
            w = 1;
        end else begin
            w = $clog2(timeout + 1);
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter for the data-memory port
//
// Purpose: shares one data-memory port between requester 0 (load/store unit)
// and requester 1 (debug/DMA). Alternates grants when both wait; terminates a
// transaction with an error after TIMEOUT BUSY cycles (TIMEOUT=0 disables).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   mN_valid_i/addr_i/wdata_i/we_i requester N request (N=0,1)
//   mN_ready_o/err_o/rdata_o      requester N completion pulse, error flag, read data
//   dmem_valid_o/addr_o/wdata_o/we_o  request to memory, muxed from granted requester
//   dmem_ready_i/rdata_i          memory completion and read data (same cycle)

module dmem_arbiter
    import riscv_defines::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        m0_valid_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] m0_wdata_i,
    input  logic [3:0]                  m0_we_i,
    output logic                        m0_ready_o,
    output logic                        m0_err_o,
    output logic [RISCV_WORD_WIDTH-1:0] m0_rdata_o,

    input  logic                        m1_valid_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] m1_wdata_i,
    input  logic [3:0]                  m1_we_i,
    output logic                        m1_ready_o,
    output logic                        m1_err_o,
    output logic [RISCV_WORD_WIDTH-1:0] m1_rdata_o,

    output logic                        dmem_valid_o,
    input  logic                        dmem_ready_i,
    output logic [RISCV_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]                  dmem_we_o,
    input  logic [RISCV_WORD_WIDTH-1:0] dmem_rdata_i
);

    localparam int            CW       = arb_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    arb_state_e    state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic pick;
    logic timeout_hit;

    // Lone requester wins; under contention the one not served last wins.
    assign pick = (m0_valid_i && m1_valid_i) ? ~last_q : m1_valid_i;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State register: FSM, grant, last and cnt together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    state_d = BUSY;
                    grant_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (dmem_ready_i || timeout_hit) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: request mux and response demux. Everything is gated by
    // BUSY so the port and both response channels read as zero in IDLE/reset.
    always_comb begin
        logic                        done;
        logic                        err;
        logic [RISCV_WORD_WIDTH-1:0] rdata;

        dmem_valid_o = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_we_o    = '0;
        m0_ready_o   = 1'b0;
        m0_err_o     = 1'b0;
        m0_rdata_o   = '0;
        m1_ready_o   = 1'b0;
        m1_err_o     = 1'b0;
        m1_rdata_o   = '0;
        done         = 1'b0;
        err          = 1'b0;
        rdata        = '0;

        if (state_q == BUSY) begin
            dmem_valid_o = 1'b1;
            dmem_addr_o  = grant_q ? m1_addr_i  : m0_addr_i;
            dmem_wdata_o = grant_q ? m1_wdata_i : m0_wdata_i;
            dmem_we_o    = grant_q ? m1_we_i    : m0_we_i;

            // A real completion beats a timeout landing in the same cycle.
            done  = dmem_ready_i || timeout_hit;
            err   = !dmem_ready_i;
            rdata = dmem_ready_i ? dmem_rdata_i : '0;

            if (grant_q) begin
                m1_ready_o = done;
                m1_err_o   = done && err;
                m1_rdata_o = rdata;
            end else begin
                m0_ready_o = done;
                m0_err_o   = done && err;
                m0_rdata_o = rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single data-memory port. It shares the port between requester 0 (the core's load/store unit) and requester 1 (a debug or DMA master). Grants alternate round-robin when both masters are waiting. A transaction that the memory never completes is terminated after a bounded number of cycles and returned to its master as an error. The block sits between the masters' memory-request interfaces and the data memory.

## Interface
Parameters:
- TIMEOUT, 16: maximum BUSY cycles before forced termination; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mN_valid_i  in  1  requester N (N=0,1) request; held until mN_ready_o
- mN_addr_i  in  RISCV_ADDR_WIDTH  requester N address; stable while valid
- mN_wdata_i  in  RISCV_WORD_WIDTH  requester N write data
- mN_we_i  in  4  requester N byte write enables; 0 = read
- mN_ready_o  out  1  one-cycle completion pulse to requester N
- mN_err_o  out  1  qualifies mN_ready_o; 1 = timed out
- mN_rdata_o  out  RISCV_WORD_WIDTH  read data, valid with mN_ready_o
- dmem_valid_o  out  1  memory request
- dmem_ready_i  in  1  memory completion; rdata valid same cycle
- dmem_addr_o, dmem_wdata_o  out  ADDR/WORD width  muxed from the granted requester
- dmem_we_o  out  4  muxed byte enables; 0 outside BUSY

## Operation
- State machine: IDLE, BUSY. Registers: state, grant (1 bit), last (1 bit), cnt.
- IDLE:
  - dmem_valid_o=0 and dmem_we_o=0.
  - Any mN_valid_i is high → go to BUSY, grant←chosen requester, last←chosen, cnt←0.
  - Choice: if only one requester is valid, choose it. If both are valid, choose the requester ≠ last.
- BUSY:
  - dmem_valid_o=1.
  - dmem_addr/wdata/we are driven combinationally from requester[grant].
- BUSY with dmem_ready_i=1:
  - m[grant]_ready_o=1, m[grant]_err_o=0, m[grant]_rdata_o=dmem_rdata_i.
  - Next state is IDLE.
- BUSY with dmem_ready_i=0:
  - If TIMEOUT≠0 and cnt==TIMEOUT-1: m[grant]_ready_o=1 and m[grant]_err_o=1, rdata=0, next state is IDLE, dmem_valid_o drops next cycle.
  - Otherwise cnt increments.
- Simultaneous ready and timeout: ready wins, err=0.
- Non-granted requester: ready_o=0, err_o=0, rdata_o=0 in every cycle.
- Granted requester drops valid mid-BUSY (protocol violation): the transaction still runs until ready or timeout, and completion is still pulsed to that requester.
- dmem_ready_i in IDLE is ignored.
- cnt width is $clog2(TIMEOUT+1), minimum 1. cnt saturates, never wraps.
- Reset, asynchronous and possibly mid-transaction: state=IDLE, grant=0, last=1 (requester 0 wins the first contest), cnt=0. All outputs are 0 while rst_n is low. Any in-flight transaction is abandoned without a completion pulse.

## Timing
- Request-to-memory latency: 1 cycle. Valid seen in IDLE at edge k → dmem_valid_o high in cycle k+1.
- Completion is combinational from dmem_ready_i to mN_ready_o (zero cycles).
- Minimum transaction is 2 cycles (1 IDLE + 1 BUSY). Back-to-back transactions always pass through one IDLE cycle.
- Timeout termination occurs in BUSY cycle number TIMEOUT, counting the first BUSY cycle as 1.
- The arbitration decision uses the mN_valid_i values sampled in IDLE. In the IDLE cycle after a completion, the completed requester's valid must already be low, or it is treated as a new request.

## Structure
- Put the arb_state_e typedef (IDLE, BUSY) in riscv_defines alongside RISCV_ADDR_WIDTH and RISCV_WORD_WIDTH.
- No sub-modules. The request mux and response demux are inline always_comb blocks. The FSM, grant, last and cnt share one always_ff block with asynchronous reset.

## Test plan
- Single read: m0 reads 0x100 and memory returns ready after 3 BUSY cycles with rdata 0xDEADBEEF → m0_ready_o pulses once with err=0 and rdata=0xDEADBEEF, and m1 outputs stay 0.
- Contention: both valid from reset, 0-wait memory → grant order is m0, m1, m0, m1. dmem_addr_o tracks the granted address, with one IDLE cycle between grants.
- Byte write: m1 drives we=4'b0100, wdata=0x00AB0000, addr 0x202 → dmem_we_o=4'b0100 and dmem_wdata_o=0x00AB0000 throughout BUSY. dmem_we_o=0 in IDLE.
- Timeout: TIMEOUT=16 and memory never ready → m0_ready_o=1 and m0_err_o=1 in BUSY cycle 16, then dmem_valid_o=0. With TIMEOUT=0 the request stays in BUSY for 100 cycles.
- Ready on the timeout cycle: memory ready in BUSY cycle 16 → err=0, data returned.
- Reset mid-BUSY: assert rst_n=0 asynchronously → all outputs are 0 immediately, with no ready pulse. After release, a new m1 request is granted normally.
